// File: rtl/ds_tdm_scheduler.sv
// rtl/ds_tdm_scheduler.sv - time-division slot scheduler sharing one output stream among up to four inputs
module ds_tdm_scheduler #(
    parameter int DW = 16,
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_load,
    input  logic [2:0]      mode_in,
    input  logic [CW-1:0]   slot_len_in,
    input  logic            skip_idle_in,
    input  logic [4*DW-1:0] ds_data,
    input  logic [3:0]      ds_valid,
    output logic [3:0]      ds_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    output logic [1:0]      out_sel,
    output logic            slot_start,
    output logic            frame_start,
    output logic            cfg_err,
    output logic            running
);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nx;

    logic [2:0]    mode, pend_mode;
    logic [CW-1:0] slot_len, pend_len, cnt;
    logic          skip, pend_skip, pend;
    logic [1:0]    sel;
    logic [DW-1:0] cur_data;

    logic cfg_legal, cfg_ok, cur_valid, slot_end, frame_end;
    logic [2:0]    nf_mode;
    logic [CW-1:0] nf_len;
    logic          nf_skip;

    assign cfg_legal = (mode_in <= 3'd4) && (slot_len_in != '0);
    assign cfg_ok    = cfg_load && cfg_legal;
    assign cur_valid = ds_valid[sel];
    assign slot_end  = (cnt == slot_len - CW'(1)) || (skip && cnt == '0 && !cur_valid);
    assign frame_end = (state == S_RUN) && slot_end && ({1'b0, sel} == mode - 3'd1);

    // A load on the last frame cycle bypasses pending and takes the next frame directly.
    assign nf_mode = cfg_ok ? mode_in      : (pend ? pend_mode : mode);
    assign nf_len  = cfg_ok ? slot_len_in  : (pend ? pend_len  : slot_len);
    assign nf_skip = cfg_ok ? skip_idle_in : (pend ? pend_skip : skip);

    always_comb begin
        case (sel)
            2'd0:    cur_data = ds_data[0*DW +: DW];
            2'd1:    cur_data = ds_data[1*DW +: DW];
            2'd2:    cur_data = ds_data[2*DW +: DW];
            default: cur_data = ds_data[3*DW +: DW];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cfg_ok && mode_in != 3'd0) state_nx = S_RUN;
            default: if (frame_end && nf_mode == 3'd0) state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        running  = (state == S_RUN);
        ds_ready = '0;
        if (state == S_RUN && !rst) ds_ready[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= '0;
            slot_len    <= CW'(1);
            skip        <= 1'b0;
            pend        <= 1'b0;
            pend_mode   <= '0;
            pend_len    <= '0;
            pend_skip   <= 1'b0;
            sel         <= '0;
            cnt         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sel     <= '0;
            slot_start  <= 1'b0;
            frame_start <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err     <= cfg_load && !cfg_legal;
            slot_start  <= (state == S_RUN) && (cnt == '0);
            frame_start <= (state == S_RUN) && (cnt == '0) && (sel == 2'd0);
            out_valid   <= (state == S_RUN) && cur_valid;
            if (state == S_RUN && cur_valid) begin
                out_data <= cur_data;
                out_sel  <= sel;
            end
            if (state == S_IDLE) begin
                sel <= '0;
                cnt <= '0;
                if (cfg_ok) begin
                    mode     <= mode_in;
                    slot_len <= slot_len_in;
                    skip     <= skip_idle_in;
                end
            end else begin
                if (cfg_ok) begin
                    pend_mode <= mode_in;
                    pend_len  <= slot_len_in;
                    pend_skip <= skip_idle_in;
                    pend      <= 1'b1;
                end
                if (slot_end) begin
                    cnt <= '0;
                    if (frame_end) begin
                        sel      <= '0;
                        mode     <= nf_mode;
                        slot_len <= nf_len;
                        skip     <= nf_skip;
                        pend     <= 1'b0;
                    end else begin
                        sel <= sel + 2'd1;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/ds_tdm_scheduler.md
# ds_tdm_scheduler

Time-division slot scheduler that shares one 16-bit output stream between up to four input data streams. It is the configurable successor to the fixed-mode multiplexers: the number of active streams and the slot length are loaded at run time. Configuration changes take effect only on frame boundaries. Each input has a valid/ready handshake, so upstream sources see exactly which cycles their words were consumed.

## Interface
- DW, 16, data width of every stream and of the output
- CW, 32, width of the slot-length configuration and the slot counter
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cfg_load  in  1  one-cycle strobe; captures mode_in, slot_len_in, skip_idle_in
- mode_in  in  3  number of active streams; 0 = stop, 1..4 = streams 0..mode-1; 5..7 illegal
- slot_len_in  in  CW  slot length in clk cycles; 0 illegal
- skip_idle_in  in  1  1 = shorten slots whose stream is idle on slot entry
- ds_data  in  4*DW  stream i data on bits [i*DW +: DW]
- ds_valid  in  4  per-stream valid
- ds_ready  out  4  per-stream ready, combinational from state
- out_data  out  DW  registered output word
- out_valid  out  1  out_data holds a consumed word
- out_sel  out  2  stream index that sourced out_data
- slot_start  out  1  marks the first output cycle of a slot
- frame_start  out  1  marks the first output cycle of a frame (stream 0's slot)
- cfg_err  out  1  one-cycle pulse on rejected cfg_load
- running  out  1  1 while in RUN

## Operation
- States are IDLE and RUN. Active config registers: mode, slot_len, skip. Pending registers hold the same fields plus a pend flag.
- On cfg_load with illegal values (mode > 4 or slot_len_in == 0):
  - cfg_err pulses in the next cycle.
  - The pending and active registers are unchanged.
- On a legal cfg_load in IDLE:
  - The values are copied straight to the active registers.
  - If mode != 0, the block enters RUN next cycle at sel = 0 and cnt = 0.
- On a legal cfg_load in RUN:
  - The values go to the pending registers and pend is set. A later load overwrites an earlier one.
  - If cfg_load coincides with the last cycle of a frame, the new values bypass the pending registers and apply to the next frame.
- RUN behaviour:
  - sel is the current stream and cnt the slot counter (CW bits).
  - ds_ready[sel] = 1; all other ready bits are 0.
  - A transfer happens when ds_valid[sel] & ds_ready[sel].
- End of slot:
  - The normal end is cnt == slot_len-1.
  - With skip = 1, if ds_valid[sel] = 0 on the slot's first cycle (cnt == 0), the slot ends after that one cycle.
  - At slot end, cnt returns to 0 and sel advances.
- End of frame: a slot end with sel == mode-1. At the frame boundary:
  - sel wraps to 0.
  - If pend is set, the pending values load into the active registers and pend clears.
  - If the new mode is 0, the block goes to IDLE instead of wrapping.
- mode = 1: stream 0 holds every slot; frame_start fires every slot.
- Arithmetic:
  - cnt compares against slot_len-1 at full CW width; no truncation.
  - slot_len = 1 gives one-cycle slots.
  - slot_len = 2^CW-1 is legal.

## Timing
- Reset values:
  - State IDLE, mode = 0, slot_len = 1, skip = 0, pend = 0, sel = 0, cnt = 0.
  - All outputs are 0, including ds_ready and out_data.
- Reset has priority over cfg_load. Reset mid-frame drops the pending config, forces ds_ready to 0 in the same cycle, and clears out_valid next cycle.
- Output latency is 1 cycle. A transfer in cycle t gives, in cycle t+1:
  - out_data = that word, out_valid = 1, out_sel = sel(t).
- If ds_valid[sel] = 0 in cycle t, then out_valid = 0 at t+1, and out_data and out_sel keep their last values.
- slot_start(t+1) = (RUN at t and cnt(t) == 0). It is asserted even when no transfer occurred.
- frame_start(t+1) = slot_start(t+1) & (sel(t) == 0).
- Start-up: a legal cfg_load in IDLE at cycle t gives:
  - running = 1 and ds_ready[0] = 1 at t+1.
  - The first slot_start and frame_start at t+2.
- Stop: the frame in progress always completes. running falls in the cycle after the frame's last cycle.

## Test plan
- Basic rotation:
  - Stimulus: reset, then cfg_load mode=3, slot_len=4, skip=0, all streams valid with DS0=0x1111, DS1=0x2222, DS2=0x3333.
  - Required: out_data gives 4×0x1111, 4×0x2222, 4×0x3333, repeating. frame_start every 12 cycles; slot_start every 4.
- Frame-boundary reconfiguration:
  - Stimulus: while running mode=3, slot_len=4, cfg_load mode=2, slot_len=2 mid-frame (cycle 5 of the frame).
  - Required: the current frame completes with 4-cycle slots. The next frame is 0x1111,0x1111,0x2222,0x2222.
  - Repeat with cfg_load on the frame's last cycle: the new config applies to the immediately following frame.
- Skip idle:
  - Stimulus: mode=4, slot_len=8, skip=1, ds_valid[1] = 0 permanently.
  - Required: stream 1's slot lasts 1 cycle with out_valid = 0 and slot_start = 1. The frame is 25 cycles.
  - With skip=0 the frame is 32 cycles, and stream 1's slot has 8 idle cycles.
- Handshake stalls:
  - Stimulus: toggle ds_valid[0] every cycle during stream 0's slot.
  - Required: ds_ready[0] is held for all slot_len cycles. out_valid follows valid delayed by 1. The number of words consumed equals the number of high-valid cycles.
- Illegal config and stop:
  - Stimulus: cfg_load mode=5, then cfg_load slot_len=0.
  - Required: each produces a cfg_err pulse, and the schedule is unchanged.
  - Then cfg_load mode=0: the current frame finishes, running drops, and all ds_ready = 0.
- Mid-frame reset:
  - Stimulus: assert rst during stream 1's slot.
  - Required: next cycle all outputs are 0 and the block is in IDLE. A subsequent cfg_load restarts at stream 0.
